// File: rtl/window_gen_kxk.sv
// window_gen_kxk: KxK sliding-window generator with K-1 circular line RAMs.
// Emits one KxK neighbourhood per centre pixel with its centre coordinates.
// BORDER_MODE 0 emits interior centres only. BORDER_MODE 1 zero-pads so that
// every input pixel becomes a centre, using internal pad steps at line and
// frame end.
//
// Ports:
//   clk, rst       rising-edge clock, asynchronous active-high reset
//   per_clken      input pixel strobe (accepted when per_ready is also high)
//   per_frame_sof  accepted pixel is (0,0) of a new frame
//   per_img_Y      input pixel
//   per_ready      block can accept a pixel this cycle
//   matrix_clken   one-cycle window-valid pulse
//   matrix_data    KxK window, row-major, element (i,j) at (i*K+j)*DATA_W
//   matrix_row     centre row of the window
//   matrix_col     centre column of the window
//   matrix_eof     high with the last window of a frame
module window_gen_kxk #(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned IMG_W       = 512,
  parameter int unsigned IMG_H       = 636,
  parameter int unsigned KSIZE       = 3,
  parameter int unsigned BORDER_MODE = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          per_clken,
  input  logic                          per_frame_sof,
  input  logic [DATA_W-1:0]             per_img_Y,
  output logic                          per_ready,
  output logic                          matrix_clken,
  output logic [KSIZE*KSIZE*DATA_W-1:0] matrix_data,
  output logic [$clog2(IMG_H)-1:0]      matrix_row,
  output logic [$clog2(IMG_W)-1:0]      matrix_col,
  output logic                          matrix_eof
);

  localparam int unsigned R     = (KSIZE - 1) / 2;
  localparam int unsigned NLB   = KSIZE - 1;
  localparam int unsigned XMAX  = (BORDER_MODE != 0) ? IMG_W - 1 + R : IMG_W - 1;
  localparam int unsigned YMAX  = (BORDER_MODE != 0) ? IMG_H - 1 + R : IMG_H - 1;
  localparam int unsigned XW    = $clog2(XMAX + 1);
  localparam int unsigned YW    = $clog2(YMAX + 1);
  localparam int unsigned AW    = $clog2(IMG_W);
  localparam int unsigned RW    = $clog2(IMG_H);
  localparam int unsigned CW    = $clog2(IMG_W);
  localparam int unsigned WIN_W = KSIZE * KSIZE * DATA_W;
  // Smallest step coordinate whose centre lies inside the emitted region.
  localparam int unsigned LO    = (BORDER_MODE != 0) ? R : 2 * R;

  typedef enum logic [1:0] {
    S_IDLE        = 2'd0,
    S_ACTIVE      = 2'd1,
    S_LINE_PAD    = 2'd2,
    S_FRAME_FLUSH = 2'd3
  } state_t;

  state_t          state, state_next;
  logic [XW-1:0]   x, x_next;
  logic [YW-1:0]   y, y_next;
  logic            ready_next;
  logic            accept;
  logic            step;
  logic            real_px;
  logic            restart;
  int unsigned     sxi, syi;

  logic [DATA_W-1:0] lb       [NLB][IMG_W];
  logic [DATA_W-1:0] win      [KSIZE][KSIZE];
  logic [DATA_W-1:0] win_next [KSIZE][KSIZE];
  logic              in_line;
  logic [AW-1:0]     addr;
  logic [DATA_W-1:0] pix_in;
  logic              lb_we;
  logic              emit;
  logic              last_step;
  logic [WIN_W-1:0]  data_next;
  logic [RW-1:0]     row_next;
  logic [CW-1:0]     col_next;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      x         <= '0;
      y         <= '0;
      per_ready <= 1'b1;
    end else begin
      state     <= state_next;
      x         <= x_next;
      y         <= y_next;
      per_ready <= ready_next;
    end
  end

  // Step qualification, step-grid counters and next state.
  always_comb begin
    state_next = state;
    x_next     = x;
    y_next     = y;
    step       = 1'b0;
    real_px    = 1'b0;
    restart    = 1'b0;
    accept     = per_clken && per_ready;

    case (state)
      S_IDLE: begin
        if (accept && per_frame_sof) begin
          step    = 1'b1;
          real_px = 1'b1;
          restart = 1'b1;
        end
      end
      S_ACTIVE: begin
        if (accept) begin
          step    = 1'b1;
          real_px = 1'b1;
          restart = per_frame_sof;
        end
      end
      S_LINE_PAD, S_FRAME_FLUSH: step = 1'b1;
      default: ;
    endcase

    // An sof pixel always lands on (0,0), abandoning any frame in progress.
    sxi = restart ? 32'd0 : 32'(x);
    syi = restart ? 32'd0 : 32'(y);

    if (real_px) begin
      state_next = S_ACTIVE;
      y_next     = YW'(syi);
      if (sxi == IMG_W - 1) begin
        if (BORDER_MODE != 0) begin
          x_next     = XW'(sxi + 1);
          state_next = S_LINE_PAD;
        end else begin
          x_next = '0;
          if (syi == IMG_H - 1) begin
            y_next     = '0;
            state_next = S_IDLE;
          end else begin
            y_next = YW'(syi + 1);
          end
        end
      end else begin
        x_next = XW'(sxi + 1);
      end
    end else if (state == S_LINE_PAD) begin
      if (sxi == XMAX) begin
        x_next     = '0;
        y_next     = YW'(syi + 1);
        state_next = (syi == IMG_H - 1) ? S_FRAME_FLUSH : S_ACTIVE;
      end else begin
        x_next = XW'(sxi + 1);
      end
    end else if (state == S_FRAME_FLUSH) begin
      if (sxi == XMAX) begin
        x_next = '0;
        if (syi == YMAX) begin
          y_next     = '0;
          state_next = S_IDLE;
        end else begin
          y_next = YW'(syi + 1);
        end
      end else begin
        x_next = XW'(sxi + 1);
      end
    end

    ready_next = (state_next == S_IDLE) || (state_next == S_ACTIVE);
  end

  // Window shift, new right column, emit decision and border masking.
  always_comb begin
    in_line   = (sxi < IMG_W);
    addr      = AW'(sxi);
    pix_in    = real_px ? per_img_Y : '0;
    // Flush rows still rotate the line RAMs (with zeros) so the real rows
    // above the bottom edge move up through the window.
    lb_we     = step && in_line;
    emit      = step && (syi >= LO) && (sxi >= LO);
    last_step = step && (syi == YMAX) && (sxi == XMAX);

    for (int unsigned i = 0; i < KSIZE; i++) begin
      for (int unsigned j = 0; j + 1 < KSIZE; j++) begin
        win_next[i][j] = win[i][j+1];
      end
    end
    for (int unsigned i = 0; i + 1 < KSIZE; i++) begin
      win_next[i][KSIZE-1] = in_line ? lb[KSIZE-2-i][addr] : '0;
    end
    win_next[KSIZE-1][KSIZE-1] = pix_in;

    // Zero elements above/left of the image: stale RAM rows and the tail of
    // the previous line would otherwise leak in.
    data_next = '0;
    for (int unsigned i = 0; i < KSIZE; i++) begin
      for (int unsigned j = 0; j < KSIZE; j++) begin
        if (!((BORDER_MODE != 0) && ((syi + i < 2 * R) || (sxi + j < 2 * R)))) begin
          data_next[(i*KSIZE+j)*DATA_W +: DATA_W] = win_next[i][j];
        end
      end
    end

    row_next = RW'(syi - R);
    col_next = CW'(sxi - R);
  end

  // Line RAMs: lb[0] holds the newest line; contents need no reset.
  always_ff @(posedge clk) begin
    if (lb_we) begin
      lb[0][addr] <= pix_in;
      for (int unsigned n = 1; n < NLB; n++) begin
        lb[n][addr] <= lb[n-1][addr];
      end
    end
  end

  // Window register and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < KSIZE; i++) begin
        for (int unsigned j = 0; j < KSIZE; j++) begin
          win[i][j] <= '0;
        end
      end
      matrix_clken <= 1'b0;
      matrix_data  <= '0;
      matrix_row   <= '0;
      matrix_col   <= '0;
      matrix_eof   <= 1'b0;
    end else begin
      if (step) begin
        for (int unsigned i = 0; i < KSIZE; i++) begin
          for (int unsigned j = 0; j < KSIZE; j++) begin
            win[i][j] <= win_next[i][j];
          end
        end
      end
      matrix_clken <= emit;
      matrix_eof   <= emit && last_step;
      if (emit) begin
        matrix_data <= data_next;
        matrix_row  <= row_next;
        matrix_col  <= col_next;
      end
    end
  end

endmodule

// File: tb/tb_window_gen_kxk.sv
// Bench for window_gen_kxk: three instances on an 8x6 image
// (a: K=3 valid-only, b: K=3 zero-pad, c: K=5 zero-pad), pixel = row*16+col.
module tb_window_gen_kxk;

  localparam int DW = 16;
  localparam int W  = 8;
  localparam int H  = 6;
  localparam int MW = 400;

  logic clk = 1'b0;
  logic rst;
  logic [2:0]         clken;
  logic [2:0]         sof;
  logic [2:0][DW-1:0] pix;
  logic [2:0]         ready;
  logic               ready_a, ready_b, ready_c;

  logic         a_clken, b_clken, c_clken;
  logic [143:0] a_data, b_data;
  logic [399:0] c_data;
  logic [2:0]   a_row, b_row, c_row;
  logic [2:0]   a_col, b_col, c_col;
  logic         a_eof, b_eof, c_eof;

  int vectors;
  int miscompares;
  int widx [3];
  int eofs [3];
  int kk   [3];
  int md   [3];
  logic [MW-1:0] last [3];

  assign ready = {ready_c, ready_b, ready_a};

  always #5 clk = ~clk;

  window_gen_kxk #(.DATA_W(DW), .IMG_W(W), .IMG_H(H), .KSIZE(3), .BORDER_MODE(0)) dut_a (
    .clk(clk), .rst(rst), .per_clken(clken[0]), .per_frame_sof(sof[0]), .per_img_Y(pix[0]),
    .per_ready(ready_a), .matrix_clken(a_clken), .matrix_data(a_data), .matrix_row(a_row),
    .matrix_col(a_col), .matrix_eof(a_eof));

  window_gen_kxk #(.DATA_W(DW), .IMG_W(W), .IMG_H(H), .KSIZE(3), .BORDER_MODE(1)) dut_b (
    .clk(clk), .rst(rst), .per_clken(clken[1]), .per_frame_sof(sof[1]), .per_img_Y(pix[1]),
    .per_ready(ready_b), .matrix_clken(b_clken), .matrix_data(b_data), .matrix_row(b_row),
    .matrix_col(b_col), .matrix_eof(b_eof));

  window_gen_kxk #(.DATA_W(DW), .IMG_W(W), .IMG_H(H), .KSIZE(5), .BORDER_MODE(1)) dut_c (
    .clk(clk), .rst(rst), .per_clken(clken[2]), .per_frame_sof(sof[2]), .per_img_Y(pix[2]),
    .per_ready(ready_c), .matrix_clken(c_clken), .matrix_data(c_data), .matrix_row(c_row),
    .matrix_col(c_col), .matrix_eof(c_eof));

  task automatic chk(string tag, logic [MW-1:0] obs, logic [MW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Golden window: zero outside the image, pixel value row*16+col inside.
  function automatic logic [MW-1:0] exp_win(int ks, int r, int c);
    logic [MW-1:0] v;
    int rr, sr, sc;
    v  = '0;
    rr = (ks - 1) / 2;
    for (int i = 0; i < ks; i++) begin
      for (int j = 0; j < ks; j++) begin
        sr = r - rr + i;
        sc = c - rr + j;
        if (sr >= 0 && sr < H && sc >= 0 && sc < W) v[(i*ks+j)*DW +: DW] = DW'(sr * 16 + sc);
      end
    end
    return v;
  endfunction

  // Windows arrive in raster order of centres; the k-th one is predictable.
  task automatic check_dut(int d, logic vld, logic [MW-1:0] data, int row, int col, logic eof);
    int rr, nc, nr, off, er, ec;
    rr  = (kk[d] - 1) / 2;
    nc  = (md[d] != 0) ? W : W - 2 * rr;
    nr  = (md[d] != 0) ? H : H - 2 * rr;
    off = (md[d] != 0) ? 0 : rr;
    if (vld) begin
      er = widx[d] / nc + off;
      ec = widx[d] % nc + off;
      chk($sformatf("d%0d_row_w%0d", d, widx[d]), MW'(row), MW'(er));
      chk($sformatf("d%0d_col_w%0d", d, widx[d]), MW'(col), MW'(ec));
      chk($sformatf("d%0d_data_w%0d", d, widx[d]), data, exp_win(kk[d], er, ec));
      chk($sformatf("d%0d_eof_w%0d", d, widx[d]), MW'(eof), MW'(widx[d] == nc * nr - 1));
      if (eof) eofs[d]++;
      widx[d]++;
      last[d] = data;
    end else begin
      chk($sformatf("d%0d_hold", d), data, last[d]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    check_dut(0, a_clken, MW'(a_data), int'(a_row), int'(a_col), a_eof);
    check_dut(1, b_clken, MW'(b_data), int'(b_row), int'(b_col), b_eof);
    check_dut(2, c_clken, MW'(c_data), int'(c_col) * 0 + int'(c_row), int'(c_col), c_eof);
  endtask

  // Present one pixel and hold it (strobe high) until the DUT takes it.
  task automatic send(int d, int r, int c, logic s, output int stalls);
    logic took;
    stalls   = 0;
    took     = 1'b0;
    clken[d] = 1'b1;
    sof[d]   = s;
    pix[d]   = DW'(r * 16 + c);
    for (int n = 0; n < 64 && !took; n++) begin
      took = ready[d];
      if (!took) stalls++;
      tick();
    end
    chk($sformatf("accept_d%0d_%0d_%0d", d, r, c), MW'(took), MW'(1'b1));
    sof[d] = 1'b0;
  endtask

  task automatic idle(int n);
    clken = '0;
    repeat (n) tick();
  endtask

  task automatic wait_ready(int d, output int cnt);
    clken[d] = 1'b0;
    cnt = 0;
    while (!ready[d] && cnt < 500) begin
      tick();
      cnt++;
    end
    chk($sformatf("ready_return_d%0d", d), MW'(ready[d]), MW'(1'b1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    int stall_tot;
    vectors     = 0;
    miscompares = 0;
    kk = '{3, 3, 5};
    md = '{0, 1, 1};
    for (int d = 0; d < 3; d++) begin
      widx[d] = 0;
      eofs[d] = 0;
      last[d] = '0;
    end
    clken = '0;
    sof   = '0;
    pix   = '0;
    rst   = 1'b1;
    tick();
    tick();

    // Reset state.
    chk("rst_ready", MW'(ready), MW'(3'b111));
    chk("rst_clken", MW'({a_clken, b_clken, c_clken}), MW'(0));
    chk("rst_eof", MW'({a_eof, b_eof, c_eof}), MW'(0));
    chk("rst_rowcol", MW'({a_row, a_col, b_row, b_col, c_row, c_col}), MW'(0));
    chk("rst_data_c", MW'(c_data), MW'(0));
    rst = 1'b0;
    tick();

    // Valid-only, continuous strobe: window one cycle after pixel (r+1,c+1).
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        send(0, r, c, (r == 0 && c == 0), st);
        chk($sformatf("a_emit_%0d_%0d", r, c), MW'(a_clken), MW'(r >= 2 && c >= 2));
        if (r == 2 && c == 2)
          chk("a_first_win", MW'(a_data),
              MW'({16'h22, 16'h21, 16'h20, 16'h12, 16'h11, 16'h10, 16'h02, 16'h01, 16'h00}));
      end
    end
    idle(3);
    chk("a_count", MW'(widx[0]), MW'(24));
    chk("a_eofs", MW'(eofs[0]), MW'(1));
    chk("a_ready_idle", MW'(ready[0]), MW'(1'b1));

    // Zero-pad K=3, strobe held high through the not-ready pad cycles.
    stall_tot = 0;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        send(1, r, c, (r == 0 && c == 0), st);
        stall_tot += st;
        chk($sformatf("b_emit_%0d_%0d", r, c), MW'(b_clken), MW'(r >= 1 && c >= 1));
        if (r == 1 && c == 1)
          chk("b_first_win", MW'(b_data),
              MW'({16'h11, 16'h10, 16'h00, 16'h01, 16'h00, 16'h00, 16'h00, 16'h00, 16'h00}));
      end
    end
    chk("b_line_stalls", MW'(stall_tot), MW'(5));
    // Last line's pad cycle followed by one flush row of 9 pad steps.
    wait_ready(1, st);
    chk("b_end_stalls", MW'(st), MW'(10));
    idle(2);
    chk("b_count", MW'(widx[1]), MW'(48));
    chk("b_eofs", MW'(eofs[1]), MW'(1));

    // Zero-pad K=5 with idle gaps in the pixel stream.
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if ((r * W + c) % 3 == 1) begin
          clken[2] = 1'b0;
          tick();
        end
        send(2, r, c, (r == 0 && c == 0), st);
      end
    end
    wait_ready(2, st);
    idle(2);
    chk("c_count", MW'(widx[2]), MW'(48));
    chk("c_eofs", MW'(eofs[2]), MW'(1));

    // Mid-frame sof at pixel (3,2): old frame yields 6 windows and no eof.
    widx[0] = 0;
    for (int p = 0; p < 3 * W + 2; p++) begin
      send(0, p / W, p % W, (p == 0), st);
    end
    chk("d_old_count", MW'(widx[0]), MW'(6));
    widx[0] = 0;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        send(0, r, c, (r == 0 && c == 0), st);
      end
    end
    idle(3);
    chk("d_new_count", MW'(widx[0]), MW'(24));
    chk("d_eofs", MW'(eofs[0]), MW'(2));

    // Reset during the frame flush of the zero-pad instance.
    widx[1] = 0;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        send(1, r, c, (r == 0 && c == 0), st);
      end
    end
    idle(3);
    chk("e_in_flush", MW'(ready[1]), MW'(1'b0));
    rst = 1'b1;
    for (int d = 0; d < 3; d++) last[d] = '0;
    tick();
    chk("e_rst_clken", MW'(b_clken), MW'(0));
    chk("e_rst_data", MW'(b_data), MW'(0));
    chk("e_rst_rowcol", MW'({b_row, b_col}), MW'(0));
    chk("e_rst_eof", MW'(b_eof), MW'(0));
    chk("e_rst_ready", MW'(ready[1]), MW'(1'b1));
    rst = 1'b0;
    widx[1] = 0;
    tick();
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < W; c++) begin
        send(1, r, c, 1'b0, st);
      end
    end
    idle(4);
    chk("e_no_sof_windows", MW'(widx[1]), MW'(0));
    chk("e_ready_idle", MW'(ready[1]), MW'(1'b1));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
